// File: rtl/seg7_output.sv
// seg7_output: AHB-Lite slave driving a 4-digit multiplexed seven-segment
// display. Software writes four hex nibbles (DATA), a decimal-point mask
// (DPMASK) and an enable bit (CTRL). A prescaled scan engine walks the
// digits and a registered output stage drives active-low SEG/DP/AN lines.
module seg7_output #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    // Register map offsets (HADDR[3:2])
    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_DPMASK = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    // Address-phase capture
    logic        rhsel_reg, rhsel_next;
    logic        rhwrite_reg, rhwrite_next;
    logic [1:0]  raddr_reg, raddr_next;

    // Software-visible registers
    logic [15:0] data_reg, data_next;
    logic [3:0]  dpmask_reg, dpmask_next;
    logic        en_reg, en_next;

    // Scan engine
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    idx_reg, idx_next;

    // Output stage
    logic [3:0]  an_reg, an_next;
    logic [6:0]  seg_reg, seg_next;
    logic        dp_reg, dp_next;

    logic        wr_en;
    logic [3:0]  digit [4];
    logic [3:0]  cur_digit;
    logic [31:0] rd_data;

    // Bits of the bus that this slave never looks at
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    // Split the DATA register into per-digit nibbles
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit[gi] = data_reg[4*gi+3 : 4*gi];
        end
    endgenerate

    assign wr_en     = rhsel_reg & rhwrite_reg;
    assign cur_digit = digit[idx_reg];

    // Address phase: latch an accepted transfer, otherwise mark the data phase idle
    always_comb begin
        rhsel_next   = HSEL & HREADY & HTRANS[1];
        rhwrite_next = rhwrite_reg;
        raddr_next   = raddr_reg;
        if (rhsel_next) begin
            rhwrite_next = HWRITE;
            raddr_next   = HADDR[3:2];
        end
    end

    // Write data phase: update the addressed register with HWDATA
    always_comb begin
        data_next   = data_reg;
        dpmask_next = dpmask_reg;
        en_next     = en_reg;
        if (wr_en) begin
            case (raddr_reg)
                A_DATA:   data_next   = HWDATA[15:0];
                A_DPMASK: dpmask_next = HWDATA[3:0];
                A_CTRL:   en_next     = HWDATA[0];
                default:  ;
            endcase
        end
    end

    // Read data phase: combinational mux of the addressed register
    always_comb begin
        rd_data = 32'd0;
        if (rhsel_reg && !rhwrite_reg) begin
            case (raddr_reg)
                A_DATA:   rd_data = {16'd0, data_reg};
                A_DPMASK: rd_data = {28'd0, dpmask_reg};
                A_CTRL:   rd_data = {31'd0, en_reg};
                default:  rd_data = 32'd0;
            endcase
        end
    end

    // Scan engine: counts only while enabled now and not being disabled this
    // cycle, so a disable landing on terminal count sends idx back to 0
    always_comb begin
        cnt_next = cnt_reg;
        idx_next = idx_reg;
        if (!(en_reg && en_next)) begin
            cnt_next = '0;
            idx_next = 2'd0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = idx_reg + 2'd1;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Output stage: hex decode of the selected digit, blank when disabled
    always_comb begin
        an_next  = 4'hF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (en_reg) begin
            an_next = ~(4'b0001 << idx_reg);
            dp_next = ~dpmask_reg[idx_reg];
            case (cur_digit)
                4'h0: seg_next = 7'h40;
                4'h1: seg_next = 7'h79;
                4'h2: seg_next = 7'h24;
                4'h3: seg_next = 7'h30;
                4'h4: seg_next = 7'h19;
                4'h5: seg_next = 7'h12;
                4'h6: seg_next = 7'h02;
                4'h7: seg_next = 7'h78;
                4'h8: seg_next = 7'h00;
                4'h9: seg_next = 7'h10;
                4'hA: seg_next = 7'h08;
                4'hB: seg_next = 7'h03;
                4'hC: seg_next = 7'h46;
                4'hD: seg_next = 7'h21;
                4'hE: seg_next = 7'h06;
                default: seg_next = 7'h0E;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rhsel_reg   <= 1'b0;
            rhwrite_reg <= 1'b0;
            raddr_reg   <= 2'd0;
            data_reg    <= 16'd0;
            dpmask_reg  <= 4'd0;
            en_reg      <= 1'b0;
            cnt_reg     <= '0;
            idx_reg     <= 2'd0;
            an_reg      <= 4'hF;
            seg_reg     <= 7'h7F;
            dp_reg      <= 1'b1;
        end else begin
            rhsel_reg   <= rhsel_next;
            rhwrite_reg <= rhwrite_next;
            raddr_reg   <= raddr_next;
            data_reg    <= data_next;
            dpmask_reg  <= dpmask_next;
            en_reg      <= en_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            an_reg      <= an_next;
            seg_reg     <= seg_next;
            dp_reg      <= dp_next;
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRDATA    = rd_data;
    assign SEG       = seg_reg;
    assign DP        = dp_reg;
    assign AN        = an_reg;

endmodule

// File: tb/tb_seg7_output.sv
// Testbench for seg7_output: table-driven register, scan and decode vectors
// plus hand-written sequences for enable/disable timing and async reset.
module tb_seg7_output;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } reg_vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } scan_vec_t;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } dec_vec_t;

    seg7_output #(.REFRESH_DIV(4)) dut (
        .HCLK      (hclk),
        .HRESETn   (hresetn),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HREADY    (hready),
        .HWDATA    (hwdata),
        .HREADYOUT (hreadyout),
        .HRDATA    (hrdata),
        .SEG       (seg),
        .DP        (dp),
        .AN        (an)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
        check({name, ".AN"},  {28'd0, an},  {28'd0, e_an});
        check({name, ".SEG"}, {25'd0, seg}, {25'd0, e_seg});
        check({name, ".DP"},  {31'd0, dp},  {31'd0, e_dp});
    endtask

    // Generic single transfer: address phase then data phase, returns 1ns after its end
    task automatic bus_write_q(input logic [31:0] addr, input logic [31:0] data,
                               input logic sel, input logic [1:0] trans, input logic rdy);
        hsel = sel; htrans = trans; hwrite = 1'b1; haddr = addr; hready = rdy;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hready = 1'b1; hwdata = data;
        @(posedge hclk); #1;
        $display("write addr=%h data=%h sel=%0b trans=%0d ready=%0b", addr, data, sel, trans, rdy);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_write_q(addr, data, 1'b1, 2'b10, 1'b1);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = addr; hready = 1'b1;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        data = hrdata;
        @(posedge hclk); #1;
        $display("read  addr=%h data=%h", addr, data);
    endtask

    initial begin
        reg_vec_t  regs [5];
        scan_vec_t scan [4];
        dec_vec_t  dec  [16];
        logic [31:0] rd;
        logic [6:0]  dec_list [16];
        bit found;

        regs[0] = '{32'h0, 32'hFFFF_ABCD, 32'h0000_ABCD};
        regs[1] = '{32'h4, 32'hFFFF_FFFA, 32'h0000_000A};
        regs[2] = '{32'h8, 32'hFFFF_FFFE, 32'h0000_0000};
        regs[3] = '{32'hC, 32'h1234_5678, 32'h0000_0000};
        regs[4] = '{32'h4, 32'h0000_0005, 32'h0000_0005};

        scan[0] = '{4'hE, 7'h19, 1'b1};
        scan[1] = '{4'hD, 7'h30, 1'b0};
        scan[2] = '{4'hB, 7'h24, 1'b1};
        scan[3] = '{4'h7, 7'h79, 1'b1};

        dec_list = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int k = 0; k < 16; k++) dec[k] = '{4'(k), dec_list[k]};

        hresetn = 1'b0; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00;
        hwrite = 1'b0; hready = 1'b1; hwdata = 32'd0;

        // Reset state
        repeat (3) @(posedge hclk);
        #1;
        check_out("reset", 4'hF, 7'h7F, 1'b1);
        check("reset.HREADYOUT", {31'd0, hreadyout}, 32'd1);
        check("reset.HRDATA", hrdata, 32'd0);
        hresetn = 1'b1;
        @(posedge hclk); #1;
        bus_read(32'h0, rd); check("reset.DATA", rd, 32'd0);
        bus_read(32'h4, rd); check("reset.DPMASK", rd, 32'd0);
        bus_read(32'h8, rd); check("reset.CTRL", rd, 32'd0);

        // Register write/read table, including the reserved slot
        for (int i = 0; i < 5; i++) begin
            bus_write(regs[i].addr, regs[i].wdata);
            bus_read(regs[i].addr, rd);
            check($sformatf("regtab[%0d]", i), rd, regs[i].rexp);
        end
        bus_read(32'h0, rd); check("reserved_wr.DATA", rd, 32'h0000_ABCD);
        check_out("disabled_blank", 4'hF, 7'h7F, 1'b1);

        // Idle / not-ready / unselected writes are ignored
        bus_write_q(32'h0, 32'h5555, 1'b1, 2'b00, 1'b1);
        bus_read(32'h0, rd); check("idle_wr", rd, 32'h0000_ABCD);
        bus_write_q(32'h0, 32'h6666, 1'b1, 2'b10, 1'b0);
        bus_read(32'h0, rd); check("hready0_wr", rd, 32'h0000_ABCD);
        bus_write_q(32'h0, 32'h7777, 1'b0, 2'b10, 1'b1);
        bus_read(32'h0, rd); check("hsel0_wr", rd, 32'h0000_ABCD);

        // Back-to-back write then read of DATA
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0;
        @(posedge hclk); #1;
        hwdata = 32'h0000_BEEF; hwrite = 1'b0; haddr = 32'h0;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        check("b2b_read", hrdata, 32'h0000_BEEF);
        $display("b2b   write/read addr=0 data=%h", hrdata);
        @(posedge hclk); #1;
        check("idle_hrdata", hrdata, 32'd0);

        // Scan sequence: 4 cycles per digit, digit 0 first
        bus_write(32'h0, 32'h1234);
        bus_write(32'h4, 32'h2);
        bus_write(32'h8, 32'h1);
        @(posedge hclk); #1;
        for (int i = 0; i < 32; i++) begin
            check_out($sformatf("scan[%0d]", i), scan[(i / 4) % 4].an,
                      scan[(i / 4) % 4].seg, scan[(i / 4) % 4].dp);
            @(posedge hclk); #1;
        end

        // Disable whose data phase coincides with cnt terminal count
        bus_write(32'h8, 32'h0);
        bus_write(32'h8, 32'h1);
        repeat (2) @(posedge hclk);
        #1;
        bus_write(32'h8, 32'h0);
        check("tc_disable.idx", {30'd0, dut.idx_reg}, 32'd0);
        check_out("tc_disable.last", 4'hE, 7'h19, 1'b1);
        @(posedge hclk); #1;
        check_out("tc_disable.blank", 4'hF, 7'h7F, 1'b1);
        bus_write(32'h8, 32'h1);
        @(posedge hclk); #1;
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("reenable[%0d]", i), scan[i / 4].an,
                      scan[i / 4].seg, scan[i / 4].dp);
            @(posedge hclk); #1;
        end

        // Decode sweep with idx pinned at 0 by restarting the scan each time
        bus_write(32'h4, 32'h0);
        for (int k = 0; k < 16; k++) begin
            bus_write(32'h8, 32'h0);
            bus_write(32'h8, 32'h1);
            bus_write(32'h0, {28'd0, dec[k].nib});
            @(posedge hclk); #1;
            check($sformatf("decode[%0h]", k), {25'd0, seg}, {25'd0, dec[k].seg});
            check($sformatf("decode_an[%0h]", k), {28'd0, an}, 32'hE);
        end

        // Reset mid-scan while digit 2 is lit
        bus_write(32'h0, 32'h1234);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (an == 4'hB) found = 1'b1;
            else begin
                @(posedge hclk); #1;
            end
        end
        check("midscan.found_digit2", {31'd0, found}, 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        check_out("midscan.reset", 4'hF, 7'h7F, 1'b1);
        check("midscan.HRDATA", hrdata, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        check_out("post_reset", 4'hF, 7'h7F, 1'b1);
        bus_read(32'h8, rd); check("post_reset.CTRL", rd, 32'd0);
        bus_read(32'h0, rd); check("post_reset.DATA", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_output.md
# seg7_output

AHB-Lite slave that drives a 4-digit multiplexed seven-segment display, the output-side counterpart of the switch input peripheral on the same bus. Software writes four hex nibbles, a decimal-point mask and an enable bit. The block time-multiplexes the digits with a programmable refresh prescaler and drives registered active-low segment and anode lines. It sits on the AHB-Lite decoder alongside the other peripherals, is zero-wait-state and raises no interrupt.

## Interface
- REFRESH_DIV, 50000: HCLK cycles each digit is lit; legal range ≥ 2.
- Clock and reset: one clock; reset is asynchronous and active-low.
- HCLK  in  1  bus and display clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the bus decoder.
- HADDR  in  32  address; only HADDR[3:2] is decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is an active transfer.
- HWRITE  in  1  1 = write, 0 = read.
- HREADY  in  1  bus ready; qualifies the address phase.
- HWDATA  in  32  write data, sampled in the data phase.
- HREADYOUT  out  1  constant 1.
- HRDATA  out  32  read data, valid in the data phase.
- SEG  out  7  active-low cathodes; bit0 = a … bit6 = g.
- DP  out  1  active-low decimal point.
- AN  out  4  active-low anodes; bit k = digit k.

## Operation
- Register map, indexed by HADDR[3:2]:
  - 0 DATA [15:0]: digit k = bits [4k+3:4k].
  - 1 DPMASK [3:0]: bit k = 1 lights the DP of digit k.
  - 2 CTRL [0]: EN.
  - 3 reserved: reads 0, writes ignored.
- Unused bits read 0.
- Address phase:
  - A transfer is accepted when HSEL & HREADY & HTRANS[1].
  - On acceptance, rHSEL, rHWRITE and rADDR[1:0] are registered.
  - With no accepted transfer, rHSEL = 0.
- Write data phase: when rHSEL & rHWRITE, HWDATA is written into the register at rADDR at the end of that cycle.
- Read data phase: when rHSEL & !rHWRITE, HRDATA is driven combinationally with the register at rADDR; HRDATA = 0 otherwise.
- Back-to-back transfers are supported. A read immediately after a write to the same address returns the new value.
- Scan engine:
  - prescale counter `cnt` runs 0..REFRESH_DIV-1.
  - 2-bit digit index `idx` advances 0→1→2→3→0 when cnt = REFRESH_DIV-1, and cnt then wraps to 0.
- Output stage, registered every cycle:
  - AN = ~(1<<idx).
  - SEG = hex decode of digit idx.
  - DP = ~DPMASK[idx].
- Hex decode, active low, listed for nibble 0–F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- EN = 0:
  - cnt and idx are held at 0.
  - Output registers load AN = F, SEG = 7F, DP = 1.
  - Register writes still take effect.
- Reset:
  - All registers 0 (EN = 0), cnt = 0, idx = 0.
  - AN = F, SEG = 7F, DP = 1, HRDATA = 0, HREADYOUT = 1.

## Timing
- Every transfer is zero-wait: HREADYOUT = 1, so the data phase is one cycle.
- Write visibility, for a DATA or DPMASK write whose data phase ends at edge E:
  - The register holds the new value after E.
  - SEG/DP reflect it after E+1, if the written digit is currently selected.
- Enable:
  - A CTRL write that sets EN at edge E: the first anode (AN = E, digit 0) drives after E+1.
  - Digit 0 is lit for REFRESH_DIV cycles, then each subsequent digit for REFRESH_DIV cycles.
- Disable: a CTRL write that clears EN at edge E blanks the outputs after E+1.
  - Clearing EN on the same cycle as cnt terminal count: the disable wins, and idx returns to 0 rather than advancing.
- Rewriting EN = 1 while already enabled does not restart cnt or idx.
- Assertion of HRESETn low at any point, including mid-transfer or mid-scan, immediately forces the reset values. Any in-flight write is lost.
- Idle or non-selected cycles (HTRANS = IDLE/BUSY, HSEL = 0, or HREADY = 0) never modify registers.

## Test plan
- Reset check: assert HRESETn low → AN = F, SEG = 7F, DP = 1, HREADYOUT = 1. Then read DATA, DPMASK and CTRL → each returns 0.
- Scan with REFRESH_DIV = 4: write DATA = 0x1234, DPMASK = 0x2, CTRL = 1 → repeating sequence of 4 cycles each:
  - AN = E, SEG = 19, DP = 1
  - AN = D, SEG = 30, DP = 0
  - AN = B, SEG = 24, DP = 1
  - AN = 7, SEG = 79, DP = 1
- Decode sweep: write DATA = 0x000k for k = 0..F with idx at 0 → SEG follows the decode list, one cycle after each write's data phase.
- Bus protocol:
  - Back-to-back write/read of DATA = 0xBEEF → read returns 0x0000BEEF.
  - Write to address 0xC → no register changes, reads 0.
  - Write with HTRANS = IDLE → ignored.
- Disable at terminal count: with EN = 1, issue a CTRL = 0 write whose data phase coincides with cnt = 3 → blank outputs next cycle, idx = 0. Re-enabling restarts at digit 0.
- Reset mid-scan: drop HRESETn at idx = 2 → outputs blank immediately. After release, EN = 0 and DATA = 0.
